led_shine: RTL and testbench



---
 rtl/led_shine.sv | 158 +++++++++++++++
 tb/tb_led_shine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_shine.sv
// ---------------------------------------------------------------------------
// led_shine
//
// Display driver for an 8-digit, common-anode seven-segment panel on the
// washing-machine controller. It time-multiplexes these values, one digit per
// scan tick:
//   - remaining time
//   - total programme time
//   - water level
//   - power/mode level
//   - a finish indicator
//
// While the cycle is finished, the time digits blink.
//
// Ports
//   clk            system clock, all registers on posedge
//   reset          asynchronous, active-high reset (blanks the panel)
//   clk_KHZ        ~1 kHz scan strobe, sampled in the clk domain
//   if_finish      wash cycle complete (shows 'F', blinks time digits)
//   counter_power  power/mode level 0..15, shown as hex on digit 5
//   water_level    water level 0..15, shown as hex on digit 4
//   time_now       remaining time 0..63, digits 1:0
//   power_off      1 blanks the whole panel at the next clk edge
//   time_all       total programme time 0..63, digits 3:2
//   state          segment pattern, active-low, [7]=dp, [6:0]=g..a
//   count          digit enables, active-low one-hot
// ---------------------------------------------------------------------------
module led_shine #(
    parameter int BLINK_BITS = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_KHZ,
    input  logic       if_finish,
    input  logic [3:0] counter_power,
    input  logic [3:0] water_level,
    input  logic [5:0] time_now,
    input  logic       power_off,
    input  logic [5:0] time_all,
    output logic [7:0] state,
    output logic [7:0] count
);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [BLINK_BITS-1:0] BLK_ONE = {{(BLINK_BITS-1){1'b0}}, 1'b1};

    logic                  kq;
    logic                  tick;
    logic [2:0]            idx;
    logic [2:0]            idx_next;
    logic [BLINK_BITS-1:0] blk;
    logic [7:0]            seg_sel;
    logic [7:0]            en_sel;

    // Tens digit of a 0..63 value; 60..63 give 6.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        if      (v >= 6'd60) t = 4'd6;
        else if (v >= 6'd50) t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return t;
    endfunction

    // Units digit of a 0..63 value.
    function automatic logic [3:0] ones_of(input logic [5:0] v);
        logic [5:0] r;
        r = v - ({2'b00, tens_of(v)} * 6'd10);
        return r[3:0];
    endfunction

    // Hex nibble to active-low segment pattern, decimal point off.
    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Only a rising edge of the strobe, seen at a clk edge, advances the scan.
    assign tick     = clk_KHZ & ~kq;
    assign idx_next = idx + 3'd1;

    // Digit content for the digit about to be selected.
    always_comb begin
        seg_sel = SEG_BLANK;
        en_sel  = ~(8'b0000_0001 << idx_next);
        case (idx_next)
            3'd0:    seg_sel = seg_of(ones_of(time_now));
            3'd1:    seg_sel = seg_of(tens_of(time_now));
            3'd2:    seg_sel = seg_of(ones_of(time_all));
            3'd3:    seg_sel = seg_of(tens_of(time_all));
            3'd4:    seg_sel = seg_of(water_level);
            3'd5:    seg_sel = seg_of(counter_power);
            3'd6:    seg_sel = if_finish ? SEG_F : SEG_BLANK;
            default: seg_sel = SEG_BLANK;
        endcase
        // Blink phase uses the counter value before this tick's increment,
        // so ticks 0..255 after finish are lit and 256..511 are dark.
        if (if_finish && blk[BLINK_BITS-1] && !idx_next[2]) begin
            seg_sel = SEG_BLANK;
        end
    end

    // Scan state, blink counter and registered panel outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kq    <= 1'b0;
            idx   <= 3'd7;
            blk   <= '0;
            count <= 8'hFF;
            state <= 8'hFF;
        end else begin
            kq <= clk_KHZ;

            if (tick) begin
                idx <= idx_next;
            end

            if (!if_finish) begin
                blk <= '0;
            end else if (tick) begin
                blk <= blk + BLK_ONE;
            end

            // power_off blanks on any clk edge; the scan keeps running so
            // the display resumes in sequence afterwards.
            if (power_off) begin
                count <= 8'hFF;
                state <= 8'hFF;
            end else if (tick) begin
                count <= en_sel;
                state <= seg_sel;
            end
        end
    end

endmodule

// File: tb/tb_led_shine.sv
module tb_led_shine;

    typedef struct {
        logic [7:0] c;
        logic [7:0] s;
        int         d;
    } exp_t;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_KHZ = 1'b0;
    logic       if_finish = 1'b0;
    logic [3:0] counter_power = 4'd0;
    logic [3:0] water_level = 4'd0;
    logic [5:0] time_now = 6'd0;
    logic       power_off = 1'b0;
    logic [5:0] time_all = 6'd0;
    logic [7:0] state;
    logic [7:0] count;

    int checks = 0;
    int failures = 0;

    logic [2:0] m_idx = 3'd7;
    logic [8:0] m_blk = 9'd0;
    exp_t       sb[$];

    led_shine #(.BLINK_BITS(9)) dut (
        .clk(clk), .reset(reset), .clk_KHZ(clk_KHZ), .if_finish(if_finish),
        .counter_power(counter_power), .water_level(water_level),
        .time_now(time_now), .power_off(power_off), .time_all(time_all),
        .state(state), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    // Expected output for the next tick, from the bench's own model.
    function automatic exp_t model_exp();
        exp_t       e;
        logic [2:0] d;
        int         v;
        d   = m_idx + 3'd1;
        e.d = int'(d);
        e.c = ~(8'h01 << d);
        v   = -1;
        case (d)
            3'd0: v = int'(time_now) % 10;
            3'd1: v = int'(time_now) / 10;
            3'd2: v = int'(time_all) % 10;
            3'd3: v = int'(time_all) / 10;
            3'd4: v = int'(water_level);
            3'd5: v = int'(counter_power);
            3'd6: v = if_finish ? 15 : -1;
            default: v = -1;
        endcase
        e.s = (v < 0) ? 8'hFF : SEG_TAB[v];
        if (if_finish && m_blk[8] && d < 3'd4) e.s = 8'hFF;
        if (power_off) begin
            e.c = 8'hFF;
            e.s = 8'hFF;
        end
        return e;
    endfunction

    task automatic push_model();
        sb.push_back(model_exp());
    endtask

    // One strobe pulse held high for 1+hold clk cycles; returns outputs
    // sampled just after the edge that detects the tick.
    task automatic drive_tick(input int hold, output logic [7:0] oc, output logic [7:0] os);
        @(negedge clk);
        clk_KHZ = 1'b1;
        @(posedge clk);
        #1;
        oc = count;
        os = state;
        m_idx = m_idx + 3'd1;
        if (if_finish) m_blk = m_blk + 9'd1;
        repeat (hold) @(negedge clk);
        @(negedge clk);
        clk_KHZ = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clk_KHZ = ~clk_KHZ;
            checks++;
            if (count !== 8'hFF || state !== 8'hFF) begin
                failures++;
                $display("FAIL reset_hold count=%h state=%h want FF/FF", count, state);
            end
        end
        @(negedge clk);
        clk_KHZ = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_idx = 3'd7;
        m_blk = 9'd0;
    endtask

    task automatic test_scan();
        logic [7:0] ce [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
        logic [7:0] se [9] = '{8'hF9, 8'hF9, 8'h90, 8'hA4, 8'hA4, 8'hC0, 8'hFF, 8'hFF, 8'hF9};
        logic [7:0] oc, os;
        exp_t e;
        time_now = 6'd11; time_all = 6'd29; water_level = 4'd2; counter_power = 4'd0;
        if_finish = 1'b0;
        for (int i = 0; i < 9; i++) begin
            e.c = ce[i]; e.s = se[i]; e.d = i % 8;
            sb.push_back(e);
            drive_tick(0, oc, os);
            e = sb.pop_front();
            checks++;
            if (oc !== e.c || os !== e.s) begin
                failures++;
                $display("FAIL scan_tick%0d count=%h state=%h want %h/%h", i + 1, oc, os, e.c, e.s);
            end
        end
    endtask

    task automatic test_hex_range();
        logic [7:0] oc, os;
        exp_t e;
        water_level = 4'd12; counter_power = 4'd15; time_now = 6'd63; time_all = 6'd60;
        for (int i = 0; i < 8; i++) begin
            push_model();
            drive_tick(0, oc, os);
            e = sb.pop_front();
            checks++;
            if (oc !== e.c || os !== e.s) begin
                failures++;
                $display("FAIL hex_digit%0d count=%h state=%h want %h/%h", e.d, oc, os, e.c, e.s);
            end
            if (e.d == 4 && os !== 8'hC6) begin
                failures++;
                $display("FAIL hex_water12 state=%h want C6", os);
            end
            if (e.d == 5 && os !== 8'h8E) begin
                failures++;
                $display("FAIL hex_power15 state=%h want 8E", os);
            end
            if (e.d == 1 && os !== 8'h82) begin
                failures++;
                $display("FAIL time63_tens state=%h want 82", os);
            end
            if (e.d == 0 && os !== 8'hB0) begin
                failures++;
                $display("FAIL time63_ones state=%h want B0", os);
            end
        end
        time_now = 6'd47; time_all = 6'd5; water_level = 4'd10; counter_power = 4'd11;
    endtask

    task automatic blink_run(input int n, input string tag);
        logic [7:0] oc, os;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            push_model();
            drive_tick(0, oc, os);
            e = sb.pop_front();
            checks++;
            if (oc !== e.c || os !== e.s) begin
                failures++;
                $display("FAIL %s tick%0d digit%0d count=%h state=%h want %h/%h",
                         tag, i, e.d, oc, os, e.c, e.s);
            end
        end
    endtask

    task automatic test_blink();
        @(negedge clk);
        if_finish = 1'b1;
        m_blk = 9'd0;
        blink_run(300, "blink_a");
        // Drop finish during the dark phase: the counter must clear.
        @(negedge clk);
        if_finish = 1'b0;
        repeat (2) @(negedge clk);
        m_blk = 9'd0;
        if_finish = 1'b1;
        blink_run(520, "blink_b");
        @(negedge clk);
        if_finish = 1'b0;
        @(negedge clk);
        m_blk = 9'd0;
    endtask

    task automatic test_power_off();
        logic [7:0] oc, os;
        exp_t e;
        @(negedge clk);
        power_off = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (count !== 8'hFF || state !== 8'hFF) begin
            failures++;
            $display("FAIL power_off_edge count=%h state=%h want FF/FF", count, state);
        end
        push_model();
        drive_tick(0, oc, os);
        e = sb.pop_front();
        checks++;
        if (oc !== e.c || os !== e.s) begin
            failures++;
            $display("FAIL power_off_tick count=%h state=%h want %h/%h", oc, os, e.c, e.s);
        end
        @(negedge clk);
        power_off = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (count !== 8'hFF || state !== 8'hFF) begin
            failures++;
            $display("FAIL power_off_release_hold count=%h state=%h want FF/FF", count, state);
        end
        for (int i = 0; i < 2; i++) begin
            push_model();
            drive_tick(0, oc, os);
            e = sb.pop_front();
            checks++;
            if (oc !== e.c || os !== e.s) begin
                failures++;
                $display("FAIL power_resume%0d count=%h state=%h want %h/%h", i, oc, os, e.c, e.s);
            end
        end
    endtask

    task automatic test_held_strobe();
        logic [7:0] oc, os;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            push_model();
            drive_tick((i == 0) ? 7 : 0, oc, os);
            e = sb.pop_front();
            checks++;
            if (oc !== e.c || os !== e.s) begin
                failures++;
                $display("FAIL held_strobe%0d count=%h state=%h want %h/%h", i, oc, os, e.c, e.s);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] oc, os;
        exp_t e;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 8'hFF || state !== 8'hFF) begin
            failures++;
            $display("FAIL async_reset count=%h state=%h want FF/FF", count, state);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clk_KHZ = ~clk_KHZ;
        end
        @(negedge clk);
        clk_KHZ = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_idx = 3'd7;
        m_blk = 9'd0;
        for (int i = 0; i < 2; i++) begin
            push_model();
            drive_tick(0, oc, os);
            e = sb.pop_front();
            checks++;
            if (oc !== e.c || os !== e.s) begin
                failures++;
                $display("FAIL post_reset%0d count=%h state=%h want %h/%h", i, oc, os, e.c, e.s);
            end
            if (i == 0 && oc !== 8'hFE) begin
                failures++;
                $display("FAIL post_reset_digit0 count=%h want FE", oc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hex_range();
        test_blink();
        test_power_off();
        test_held_strobe();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
